// File: rtl/reset_sequencer.sv
// Ordered release of per-subsystem active-low resets, gated by PLL lock and
// per-stage ready acknowledges, with ack timeout and lock-loss supervision.
module reset_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILT   = 8,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                CK,
    input  logic                RST,
    input  logic                PLL_LOCKED,
    input  logic                SOFT_RST,
    input  logic [N_STAGES-1:0] STAGE_ACK,
    output logic [N_STAGES-1:0] STAGE_RSTb,
    output logic                ALL_READY,
    output logic                TIMEOUT_ERR,
    output logic [2:0]          FAULT_STAGE,
    output logic [7:0]          LOCK_LOSS,
    output logic [2:0]          STATE
);

    localparam int IDX_W  = (N_STAGES    > 1) ? $clog2(N_STAGES)    : 1;
    localparam int LOCK_W = (LOCK_FILT   > 1) ? $clog2(LOCK_FILT)   : 1;
    localparam int DLY_W  = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_STAGES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_DELAY     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [LOCK_W-1:0] lock_cnt;
    logic [DLY_W-1:0]  dly_cnt;
    logic [TO_W-1:0]   to_cnt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Lock loss only matters once the sequence has started releasing stages
    logic lock_lost;
    assign lock_lost = !PLL_LOCKED &&
                       (state == S_DELAY || state == S_WAIT_ACK || state == S_RUN);

    always_ff @(posedge CK) begin
        if (RST) begin
            state       <= S_HOLD;
            STAGE_RSTb  <= '0;
            ALL_READY   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            FAULT_STAGE <= 3'd0;
            LOCK_LOSS   <= 8'd0;
            idx         <= '0;
            lock_cnt    <= '0;
            dly_cnt     <= '0;
            to_cnt      <= '0;
        end else if (SOFT_RST) begin
            state       <= S_HOLD;
            STAGE_RSTb  <= '0;
            ALL_READY   <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            FAULT_STAGE <= 3'd0;
            idx         <= '0;
            lock_cnt    <= '0;
            dly_cnt     <= '0;
            to_cnt      <= '0;
        end else if (lock_lost) begin
            state      <= S_HOLD;
            STAGE_RSTb <= '0;
            ALL_READY  <= 1'b0;
            LOCK_LOSS  <= sat_inc8(LOCK_LOSS);
            idx        <= '0;
            lock_cnt   <= '0;
            dly_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    STAGE_RSTb <= '0;
                    ALL_READY  <= 1'b0;
                    idx        <= '0;
                    lock_cnt   <= '0;
                    state      <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (!PLL_LOCKED) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        lock_cnt <= '0;
                        dly_cnt  <= '0;
                        state    <= S_DELAY;
                    end else begin
                        lock_cnt <= lock_cnt + LOCK_W'(1);
                    end
                end
                S_DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        STAGE_RSTb[idx] <= 1'b1;
                        dly_cnt         <= '0;
                        to_cnt          <= '0;
                        state           <= S_WAIT_ACK;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (STAGE_ACK[idx]) begin
                        if (idx == IDX_LAST) begin
                            ALL_READY <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            dly_cnt <= '0;
                            state   <= S_DELAY;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        STAGE_RSTb  <= '0;
                        ALL_READY   <= 1'b0;
                        TIMEOUT_ERR <= 1'b1;
                        FAULT_STAGE <= 3'(idx);
                        state       <= S_FAULT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_RUN: begin
                    ALL_READY <= 1'b1;
                end
                S_FAULT: begin
                    STAGE_RSTb  <= '0;
                    ALL_READY   <= 1'b0;
                    TIMEOUT_ERR <= 1'b1;
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a vector table for the nominal flow and
// lock filter, plus hand-written sequences for ack, timeout and lock-loss cases.
module tb_reset_sequencer;

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_DELAY     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    logic       CK;
    logic       RST;
    logic       PLL_LOCKED;
    logic       SOFT_RST;
    logic [3:0] STAGE_ACK;
    logic [3:0] STAGE_RSTb;
    logic       ALL_READY;
    logic       TIMEOUT_ERR;
    logic [2:0] FAULT_STAGE;
    logic [7:0] LOCK_LOSS;
    logic [2:0] STATE;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    reset_sequencer #(
        .N_STAGES    (4),
        .STAGE_DELAY (16),
        .LOCK_FILT   (8),
        .ACK_TIMEOUT (1023)
    ) dut (
        .CK          (CK),
        .RST         (RST),
        .PLL_LOCKED  (PLL_LOCKED),
        .SOFT_RST    (SOFT_RST),
        .STAGE_ACK   (STAGE_ACK),
        .STAGE_RSTb  (STAGE_RSTb),
        .ALL_READY   (ALL_READY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .FAULT_STAGE (FAULT_STAGE),
        .LOCK_LOSS   (LOCK_LOSS),
        .STATE       (STATE)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        bit         rst;
        int         cyc;
        logic       lock;
        logic [3:0] ack;
        logic [3:0] rstb;
        logic       ready;
        logic [2:0] state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input int c, input logic l, input logic [3:0] a,
                       input logic [3:0] rb, input logic rd, input logic [2:0] st);
        vec_t v;
        v.rst = r; v.cyc = c; v.lock = l; v.ack = a;
        v.rstb = rb; v.ready = rd; v.state = st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
        edge_n++;
    endtask

    task automatic tick_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (STATE !== target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(STATE), 32'(target));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_state"}, 32'(STATE), 32'(S_HOLD));
        chk({name, "_rstb"}, 32'(STAGE_RSTb), 32'h0);
        chk({name, "_ready"}, 32'(ALL_READY), 32'h0);
        chk({name, "_err"}, 32'(TIMEOUT_ERR), 32'h0);
        chk({name, "_fstage"}, 32'(FAULT_STAGE), 32'h0);
        chk({name, "_lockloss"}, 32'(LOCK_LOSS), 32'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1; SOFT_RST = 1'b0; PLL_LOCKED = 1'b0; STAGE_ACK = 4'h0;
        tick();
        tick();
        chk_reset_vals("reset");
        RST = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        RST = 1'b1; SOFT_RST = 1'b0; PLL_LOCKED = 1'b0; STAGE_ACK = 4'h0;

        // Nominal: all acks high, releases at edges 25, 42, 59, 76, RUN at 77
        add(1,   1, 1'b1, 4'hF, 4'h0, 1'b0, S_WAIT_LOCK);
        add(0,   8, 1'b1, 4'hF, 4'h0, 1'b0, S_WAIT_LOCK);
        add(0,   9, 1'b1, 4'hF, 4'h0, 1'b0, S_DELAY);
        add(0,  24, 1'b1, 4'hF, 4'h0, 1'b0, S_DELAY);
        add(0,  25, 1'b1, 4'hF, 4'h1, 1'b0, S_WAIT_ACK);
        add(0,  26, 1'b1, 4'hF, 4'h1, 1'b0, S_DELAY);
        add(0,  41, 1'b1, 4'hF, 4'h1, 1'b0, S_DELAY);
        add(0,  42, 1'b1, 4'hF, 4'h3, 1'b0, S_WAIT_ACK);
        add(0,  58, 1'b1, 4'hF, 4'h3, 1'b0, S_DELAY);
        add(0,  59, 1'b1, 4'hF, 4'h7, 1'b0, S_WAIT_ACK);
        add(0,  75, 1'b1, 4'hF, 4'h7, 1'b0, S_DELAY);
        add(0,  76, 1'b1, 4'hF, 4'hF, 1'b0, S_WAIT_ACK);
        add(0,  77, 1'b1, 4'hF, 4'hF, 1'b1, S_RUN);
        add(0, 100, 1'b1, 4'hF, 4'hF, 1'b1, S_RUN);
        // Lock filter: 5 highs, one low, then 8 fresh highs needed
        add(1,   6, 1'b1, 4'hF, 4'h0, 1'b0, S_WAIT_LOCK);
        add(0,   7, 1'b0, 4'hF, 4'h0, 1'b0, S_WAIT_LOCK);
        add(0,  14, 1'b1, 4'hF, 4'h0, 1'b0, S_WAIT_LOCK);
        add(0,  15, 1'b1, 4'hF, 4'h0, 1'b0, S_DELAY);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            PLL_LOCKED = vecs[i].lock;
            STAGE_ACK  = vecs[i].ack;
            tick_to(vecs[i].cyc);
            chk($sformatf("vec%0d_state", i), 32'(STATE), 32'(vecs[i].state));
            chk($sformatf("vec%0d_rstb", i), 32'(STAGE_RSTb), 32'(vecs[i].rstb));
            chk($sformatf("vec%0d_ready", i), 32'(ALL_READY), 32'(vecs[i].ready));
        end

        // Slow ack on stage 1
        do_reset();
        PLL_LOCKED = 1'b1; STAGE_ACK = 4'b1101;
        tick_to(42);
        chk("slow_rel1", 32'(STAGE_RSTb), 32'h3);
        tick_to(91);
        chk("slow_waiting", 32'(STATE), 32'(S_WAIT_ACK));
        STAGE_ACK = 4'hF;
        tick_to(92);
        chk("slow_ack_seen", 32'(STATE), 32'(S_DELAY));
        tick_to(107);
        chk("slow_pre_rel2", 32'(STAGE_RSTb), 32'h3);
        tick_to(108);
        chk("slow_rel2", 32'(STAGE_RSTb), 32'h7);
        wait_state(S_RUN, 100, "slow_run");
        chk("slow_no_err", 32'(TIMEOUT_ERR), 32'h0);

        // Timeout on stage 2: WAIT_ACK entered at edge 59, fault at 59+1023
        do_reset();
        PLL_LOCKED = 1'b1; STAGE_ACK = 4'b1011;
        tick_to(59);
        chk("to_rel2", 32'(STAGE_RSTb), 32'h7);
        tick_to(1081);
        chk("to_still_wait", 32'(STATE), 32'(S_WAIT_ACK));
        chk("to_no_err_yet", 32'(TIMEOUT_ERR), 32'h0);
        tick_to(1082);
        chk("to_state", 32'(STATE), 32'(S_FAULT));
        chk("to_err", 32'(TIMEOUT_ERR), 32'h1);
        chk("to_fstage", 32'(FAULT_STAGE), 32'h2);
        chk("to_rstb", 32'(STAGE_RSTb), 32'h0);
        PLL_LOCKED = 1'b0;
        tick_to(1090);
        chk("fault_sticky", 32'(STATE), 32'(S_FAULT));
        chk("fault_no_lockloss", 32'(LOCK_LOSS), 32'h0);
        SOFT_RST = 1'b1;
        tick();
        chk("soft_state", 32'(STATE), 32'(S_HOLD));
        chk("soft_err", 32'(TIMEOUT_ERR), 32'h0);
        chk("soft_fstage", 32'(FAULT_STAGE), 32'h0);
        SOFT_RST = 1'b0; PLL_LOCKED = 1'b1; STAGE_ACK = 4'hF;
        tick();
        chk("soft_restart", 32'(STATE), 32'(S_WAIT_LOCK));
        wait_state(S_RUN, 200, "soft_reseq_run");

        // One-cycle lock drop in RUN
        PLL_LOCKED = 1'b0;
        tick();
        chk("ll_state", 32'(STATE), 32'(S_HOLD));
        chk("ll_rstb", 32'(STAGE_RSTb), 32'h0);
        chk("ll_ready", 32'(ALL_READY), 32'h0);
        chk("ll_count", 32'(LOCK_LOSS), 32'h1);
        PLL_LOCKED = 1'b1;
        edge_n = 0;
        tick_to(1);
        chk("ll_wait_lock", 32'(STATE), 32'(S_WAIT_LOCK));
        tick_to(76);
        chk("ll_rel3", 32'(STAGE_RSTb), 32'hF);
        chk("ll_not_ready", 32'(ALL_READY), 32'h0);
        tick_to(77);
        chk("ll_run", 32'(STATE), 32'(S_RUN));

        // SOFT_RST and lock loss together: counted as SOFT_RST only
        SOFT_RST = 1'b1; PLL_LOCKED = 1'b0;
        tick();
        chk("sim_state", 32'(STATE), 32'(S_HOLD));
        chk("sim_count", 32'(LOCK_LOSS), 32'h1);
        chk("sim_rstb", 32'(STAGE_RSTb), 32'h0);
        SOFT_RST = 1'b0; PLL_LOCKED = 1'b1;
        edge_n = 0;
        tick_to(25);
        chk("mid_wait_ack", 32'(STATE), 32'(S_WAIT_ACK));
        chk("mid_rel0", 32'(STAGE_RSTb), 32'h1);
        RST = 1'b1;
        tick();
        chk_reset_vals("mid_rst");
        RST = 1'b0;

        // Lock-loss saturation
        for (int i = 1; i <= 260; i++) begin
            PLL_LOCKED = 1'b1;
            wait_state(S_DELAY, 20, "sat_reach_delay");
            PLL_LOCKED = 1'b0;
            tick();
            if (i == 1 || i == 254 || i == 255 || i == 260)
                chk($sformatf("sat_count_%0d", i), 32'(LOCK_LOSS), (i > 255) ? 32'd255 : 32'(i));
        end
        chk("sat_state", 32'(STATE), 32'(S_HOLD));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
